// File: rtl/cpu_pkg.sv
// Shared core definitions: reset PC and the fetch FSM state encoding.
package cpu_pkg;

  localparam int unsigned XLEN     = 32;
  localparam logic [31:0] RESET_PC = 32'h0000_3000;

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2,
    ERR  = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/pc_fetch_if.sv
// Fetch-stage bus: instruction-memory request/grant/response and the decode valid/ready link.
interface pc_fetch_if;
  import cpu_pkg::*;

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_gnt;
  logic            imem_rvalid;
  logic [XLEN-1:0] imem_rdata;
  logic            if_valid;
  logic [XLEN-1:0] if_instr;
  logic [XLEN-1:0] if_pc;
  logic            id_ready;

  modport master (
    output imem_req, imem_addr, if_valid, if_instr, if_pc,
    input  imem_gnt, imem_rvalid, imem_rdata, id_ready
  );

  modport slave (
    input  imem_req, imem_addr, if_valid, if_instr, if_pc,
    output imem_gnt, imem_rvalid, imem_rdata, id_ready
  );

endinterface

// File: rtl/pc_fetch.sv
// MIPS fetch stage: one outstanding instruction fetch at a time, handed to decode
// over valid/ready; a misaligned next PC parks the stage in a sticky error state.
module pc_fetch
  import cpu_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  pc_fetch_if.master         bus,
  input  logic [XLEN-1:0]    nextpc,
  output logic [XLEN-1:0]    pc,
  output logic               fetch_err,
  output logic [CNT_W-1:0]   fetch_cnt
);

  fetch_state_t     r_state, w_state_nxt;
  logic [XLEN-1:0]  r_pc, w_pc_nxt;
  logic [XLEN-1:0]  r_if_instr, w_if_instr_nxt;
  logic [XLEN-1:0]  r_if_pc, w_if_pc_nxt;
  logic             r_if_valid, w_if_valid_nxt;
  logic             r_err, w_err_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= REQ;
      r_pc       <= RESET_PC;
      r_if_instr <= '0;
      r_if_pc    <= RESET_PC;
      r_if_valid <= 1'b0;
      r_err      <= 1'b0;
      r_cnt      <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_pc       <= w_pc_nxt;
      r_if_instr <= w_if_instr_nxt;
      r_if_pc    <= w_if_pc_nxt;
      r_if_valid <= w_if_valid_nxt;
      r_err      <= w_err_nxt;
      r_cnt      <= w_cnt_nxt;
    end
  end

  // Inputs are only looked at in the state that owns them, so stray gnt/rvalid are ignored.
  always_comb begin
    w_state_nxt    = r_state;
    w_pc_nxt       = r_pc;
    w_if_instr_nxt = r_if_instr;
    w_if_pc_nxt    = r_if_pc;
    w_if_valid_nxt = r_if_valid;
    w_err_nxt      = r_err;
    w_cnt_nxt      = r_cnt;
    unique case (r_state)
      REQ: begin
        if (bus.imem_gnt) w_state_nxt = WAIT;
      end
      WAIT: begin
        if (bus.imem_rvalid) begin
          w_if_instr_nxt = bus.imem_rdata;
          w_if_pc_nxt    = r_pc;
          w_if_valid_nxt = 1'b1;
          w_state_nxt    = HOLD;
        end
      end
      HOLD: begin
        if (r_if_valid && bus.id_ready) begin
          w_pc_nxt       = nextpc;
          w_if_valid_nxt = 1'b0;
          w_cnt_nxt      = r_cnt + CNT_W'(1);
          if (nextpc[1:0] == 2'b00) begin
            w_state_nxt = REQ;
          end else begin
            w_state_nxt = ERR;
            w_err_nxt   = 1'b1;
          end
        end
      end
      ERR: begin
        w_state_nxt = ERR;
      end
      default: w_state_nxt = REQ;
    endcase
  end

  // Request is a pure state decode; the reset gate keeps it low while reset is held.
  assign bus.imem_req  = rst && (r_state == REQ);
  assign bus.imem_addr = r_pc;
  assign bus.if_valid  = r_if_valid;
  assign bus.if_instr  = r_if_instr;
  assign bus.if_pc     = r_if_pc;
  assign pc            = r_pc;
  assign fetch_err     = r_err;
  assign fetch_cnt     = r_cnt;

endmodule

// File: tb/tb_pc_fetch.sv
// Directed bench for pc_fetch with hand-computed expectations at each step.
module tb_pc_fetch;
  import cpu_pkg::*;

  logic        clk;
  logic        rst;
  logic [31:0] nextpc;
  logic [31:0] pc;
  logic        fetch_err;
  logic [31:0] fetch_cnt;
  logic        ovr_en;
  logic [31:0] ovr_pc;

  int n_vec;
  int n_err;

  pc_fetch_if bus ();

  pc_fetch #(.CNT_W(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .nextpc    (nextpc),
    .pc        (pc),
    .fetch_err (fetch_err),
    .fetch_cnt (fetch_cnt)
  );

  // Next-PC logic stand-in: sequential unless a redirect target is forced.
  assign nextpc = ovr_en ? ovr_pc : pc + 32'd4;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_vec           = 0;
    n_err           = 0;
    rst             = 1'b0;
    ovr_en          = 1'b0;
    ovr_pc          = 32'h0;
    bus.imem_gnt    = 1'b0;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = 32'h0;
    bus.id_ready    = 1'b0;

    // Reset values
    step();
    chk("rst_req",    {31'b0, bus.imem_req}, 32'd0);
    chk("rst_pc",     pc, 32'h0000_3000);
    chk("rst_if_pc",  bus.if_pc, 32'h0000_3000);
    chk("rst_instr",  bus.if_instr, 32'h0);
    chk("rst_valid",  {31'b0, bus.if_valid}, 32'd0);
    chk("rst_err",    {31'b0, fetch_err}, 32'd0);
    chk("rst_cnt",    fetch_cnt, 32'd0);

    // Reset then run: best-case 3-cycle fetch
    rst = 1'b1;
    #1;
    chk("c0_req",  {31'b0, bus.imem_req}, 32'd1);
    chk("c0_addr", bus.imem_addr, 32'h0000_3000);
    bus.imem_gnt = 1'b1;
    step();
    chk("c1_req", {31'b0, bus.imem_req}, 32'd0);
    bus.imem_gnt    = 1'b0;
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = 32'h2008_0005;
    step();
    chk("c2_valid", {31'b0, bus.if_valid}, 32'd1);
    chk("c2_if_pc", bus.if_pc, 32'h0000_3000);
    chk("c2_instr", bus.if_instr, 32'h2008_0005);
    bus.imem_rvalid = 1'b0;
    bus.id_ready    = 1'b1;
    step();
    chk("c3_pc",    pc, 32'h0000_3004);
    chk("c3_cnt",   fetch_cnt, 32'd1);
    chk("c3_req",   {31'b0, bus.imem_req}, 32'd1);
    chk("c3_addr",  bus.imem_addr, 32'h0000_3004);
    chk("c3_valid", {31'b0, bus.if_valid}, 32'd0);

    // Grant stall; a stray rvalid in REQ must be ignored
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = 32'hBAD0_0001;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("stall_req",   {31'b0, bus.imem_req}, 32'd1);
      chk("stall_addr",  bus.imem_addr, 32'h0000_3004);
      chk("stall_valid", {31'b0, bus.if_valid}, 32'd0);
    end
    bus.imem_rvalid = 1'b0;
    bus.imem_gnt    = 1'b1;
    step();
    chk("gnt_req", {31'b0, bus.imem_req}, 32'd0);

    // Decode backpressure with nextpc wobbling during the stall
    bus.imem_gnt    = 1'b0;
    bus.id_ready    = 1'b0;
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = 32'h8C01_0010;
    step();
    bus.imem_rvalid = 1'b0;
    ovr_en          = 1'b1;
    for (int i = 0; i < 3; i++) begin
      ovr_pc = 32'h1111_0000 + 32'(i);
      step();
      chk("bp_valid", {31'b0, bus.if_valid}, 32'd1);
      chk("bp_instr", bus.if_instr, 32'h8C01_0010);
      chk("bp_if_pc", bus.if_pc, 32'h0000_3004);
      chk("bp_req",   {31'b0, bus.imem_req}, 32'd0);
      chk("bp_pc",    pc, 32'h0000_3004);
      chk("bp_err",   {31'b0, fetch_err}, 32'd0);
    end

    // Branch redirect at accept
    ovr_pc       = 32'h0000_3040;
    bus.id_ready = 1'b1;
    step();
    chk("br_addr", bus.imem_addr, 32'h0000_3040);
    chk("br_req",  {31'b0, bus.imem_req}, 32'd1);
    chk("br_cnt",  fetch_cnt, 32'd2);

    // Misaligned target
    bus.imem_gnt = 1'b1;
    step();
    bus.imem_gnt    = 1'b0;
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = 32'h0800_0C10;
    step();
    chk("mis_if_pc", bus.if_pc, 32'h0000_3040);
    bus.imem_rvalid = 1'b0;
    ovr_pc          = 32'h0000_3006;
    step();
    chk("mis_err",   {31'b0, fetch_err}, 32'd1);
    chk("mis_pc",    pc, 32'h0000_3006);
    chk("mis_cnt",   fetch_cnt, 32'd3);
    chk("mis_valid", {31'b0, bus.if_valid}, 32'd0);
    bus.imem_gnt    = 1'b1;
    bus.imem_rvalid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("err_req",   {31'b0, bus.imem_req}, 32'd0);
      chk("err_valid", {31'b0, bus.if_valid}, 32'd0);
      chk("err_flag",  {31'b0, fetch_err}, 32'd1);
      chk("err_cnt",   fetch_cnt, 32'd3);
    end
    bus.imem_gnt    = 1'b0;
    bus.imem_rvalid = 1'b0;
    rst             = 1'b0;
    #1;
    chk("clr_err", {31'b0, fetch_err}, 32'd0);
    chk("clr_pc",  pc, 32'h0000_3000);
    chk("clr_cnt", fetch_cnt, 32'd0);
    step();
    rst    = 1'b1;
    ovr_en = 1'b0;

    // Reset while in WAIT, late rvalid afterwards
    bus.imem_gnt = 1'b1;
    step();
    chk("w_req", {31'b0, bus.imem_req}, 32'd0);
    bus.imem_gnt = 1'b0;
    rst          = 1'b0;
    #1;
    chk("wr_req",   {31'b0, bus.imem_req}, 32'd0);
    chk("wr_valid", {31'b0, bus.if_valid}, 32'd0);
    step();
    rst             = 1'b1;
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = 32'hDEAD_BEEF;
    step();
    chk("late_valid", {31'b0, bus.if_valid}, 32'd0);
    chk("late_req",   {31'b0, bus.imem_req}, 32'd1);
    chk("late_addr",  bus.imem_addr, 32'h0000_3000);
    chk("late_instr", bus.if_instr, 32'h0);
    bus.imem_rvalid = 1'b0;
    bus.imem_gnt    = 1'b1;
    step();
    bus.imem_gnt    = 1'b0;
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = 32'h2409_0001;
    step();
    chk("rs_valid", {31'b0, bus.if_valid}, 32'd1);
    chk("rs_instr", bus.if_instr, 32'h2409_0001);
    chk("rs_if_pc", bus.if_pc, 32'h0000_3000);
    bus.imem_rvalid = 1'b0;
    step();
    chk("rs_pc",  pc, 32'h0000_3004);
    chk("rs_cnt", fetch_cnt, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
